// File: rtl/xor_end_tag_tx.sv
// End-of-permutation XOR stage: applies key / domain-separation XORs to the captured
// state and optionally streams the 128-bit tag (x3, then x4) over valid/ready.
module xor_end_tag_tx #(
  parameter int DOMAIN_SEP_POS = 0,
  parameter int TAG_WORDS      = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [4:0][63:0] i_state,
  input  logic [127:0]     i_key,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_enable_xor_key,
  input  logic             i_enable_xor_lsb,
  input  logic             i_enable_tag,
  output logic [4:0][63:0] o_state,
  output logic             o_state_valid,
  output logic [63:0]      o_tag_data,
  output logic             o_tag_valid,
  output logic             o_tag_last,
  input  logic             i_tag_ready
);

  typedef enum logic [1:0] {
    IDLE,
    TAG_HI,
    TAG_LO
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             capture;
  logic [4:0][63:0] xored;
  logic [63:0]      sep_mask;

  assign capture  = i_valid && (state == IDLE);
  assign sep_mask = 64'd1 << DOMAIN_SEP_POS;

  always_comb begin
    xored = i_state;
    if (i_enable_xor_key) begin
      xored[3] = xored[3] ^ i_key[127:64];
      xored[4] = xored[4] ^ i_key[63:0];
    end
    if (i_enable_xor_lsb) begin
      xored[4] = xored[4] ^ sep_mask;
    end
  end

  // o_state only changes on an accepted capture, so it doubles as the tag word buffer.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      o_state       <= '0;
      o_state_valid <= 1'b0;
    end else begin
      state         <= state_next;
      o_state_valid <= capture;
      if (capture) begin
        o_state <= xored;
      end
    end
  end

  always_comb begin
    state_next  = state;
    o_ready     = 1'b0;
    o_tag_valid = 1'b0;
    o_tag_last  = 1'b0;
    o_tag_data  = '0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid && i_enable_tag) begin
          state_next = TAG_HI;
        end
      end
      TAG_HI: begin
        o_tag_valid = 1'b1;
        o_tag_data  = o_state[3];
        o_tag_last  = (TAG_WORDS == 1);
        if (i_tag_ready) begin
          state_next = (TAG_WORDS == 2) ? TAG_LO : IDLE;
        end
      end
      TAG_LO: begin
        o_tag_valid = 1'b1;
        o_tag_data  = o_state[4];
        o_tag_last  = 1'b1;
        if (i_tag_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_xor_end_tag_tx.sv
// Self-checking bench for xor_end_tag_tx: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the tag stream.
module tb_xor_end_tag_tx;

  logic             clk;
  logic             reset;
  logic [4:0][63:0] st;
  logic [127:0]     key;
  logic             valid, key_en, lsb_en, tag_en, tag_ready;
  logic             ready, state_valid, tag_valid, tag_last;
  logic [4:0][63:0] ostate;
  logic [63:0]      tag_data;

  logic [4:0][63:0] b_st;
  logic             b_valid, b_lsb_en, b_tag_ready;
  logic             b_ready, b_state_valid, b_tag_valid, b_tag_last;
  logic [4:0][63:0] b_ostate;
  logic [63:0]      b_tag_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0][63:0] m_state;
  logic             m_sv;
  logic [64:0]      m_q[$];

  xor_end_tag_tx #(.DOMAIN_SEP_POS(0), .TAG_WORDS(2)) dut (
    .i_clock(clk), .i_reset(reset), .i_state(st), .i_key(key), .i_valid(valid),
    .o_ready(ready), .i_enable_xor_key(key_en), .i_enable_xor_lsb(lsb_en),
    .i_enable_tag(tag_en), .o_state(ostate), .o_state_valid(state_valid),
    .o_tag_data(tag_data), .o_tag_valid(tag_valid), .o_tag_last(tag_last),
    .i_tag_ready(tag_ready)
  );

  xor_end_tag_tx #(.DOMAIN_SEP_POS(37), .TAG_WORDS(1)) dut_b (
    .i_clock(clk), .i_reset(reset), .i_state(b_st), .i_key(128'h0), .i_valid(b_valid),
    .o_ready(b_ready), .i_enable_xor_key(1'b0), .i_enable_xor_lsb(b_lsb_en),
    .i_enable_tag(1'b1), .o_state(b_ostate), .o_state_valid(b_state_valid),
    .o_tag_data(b_tag_data), .o_tag_valid(b_tag_valid), .o_tag_last(b_tag_last),
    .i_tag_ready(b_tag_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0][63:0] end_xor(input logic [4:0][63:0] s,
                                               input logic [127:0] k,
                                               input logic ke, input logic le);
    logic [4:0][63:0] r;
    r = s;
    if (ke) begin
      r[3] = r[3] ^ k[127:64];
      r[4] = r[4] ^ k[63:0];
    end
    if (le) r[4] = r[4] ^ 64'd1;
    return r;
  endfunction

  // Model view: pending tag words sit in a queue; the block is ready only when it is empty.
  task automatic model_edge();
    bit idle;
    if (reset) begin
      m_state = '0;
      m_sv    = 1'b0;
      m_q.delete();
    end else begin
      idle = (m_q.size() == 0);
      m_sv = 1'b0;
      if (!idle && tag_ready) void'(m_q.pop_front());
      if (idle && valid) begin
        m_state = end_xor(st, key, key_en, lsb_en);
        m_sv    = 1'b1;
        if (tag_en) begin
          m_q.push_back({1'b0, m_state[3]});
          m_q.push_back({1'b1, m_state[4]});
        end
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_state(output logic [4:0][63:0] s);
    for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %0b want 1", ready); end
    n_checks++; if (state_valid !== 1'b0 || tag_valid !== 1'b0 || tag_last !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags: got sv=%0b tv=%0b tl=%0b want 0", state_valid, tag_valid, tag_last); end
    n_checks++; if (ostate !== '0 || tag_data !== 64'h0) begin
      n_fail++; $display("[TB] FAIL reset_data: got %h / %h want 0", ostate, tag_data); end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_key_xor();
    logic [4:0][63:0] s;
    rand_state(s);
    s[3] = '0; s[4] = '0;
    st = s; key = 128'h0123456789ABCDEF_FEDCBA9876543210;
    key_en = 1'b1; lsb_en = 1'b0; tag_en = 1'b0; valid = 1'b1;
    cycle();
    valid = 1'b0; key_en = 1'b0;
    n_checks++; if (ostate[3] !== 64'h0123456789ABCDEF) begin n_fail++; $display("[TB] FAIL key_x3: got %h want 0123456789abcdef", ostate[3]); end
    n_checks++; if (ostate[4] !== 64'hFEDCBA9876543210) begin n_fail++; $display("[TB] FAIL key_x4: got %h want fedcba9876543210", ostate[4]); end
    n_checks++; if (ostate[2:0] !== s[2:0]) begin n_fail++; $display("[TB] FAIL key_x012: got %h want %h", ostate[2:0], s[2:0]); end
    n_checks++; if (state_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL key_sv_rise: got %0b want 1", state_valid); end
    n_checks++; if (ready !== 1'b1 || tag_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL key_no_tag: got rdy=%0b tv=%0b want 1/0", ready, tag_valid); end
    cycle();
    n_checks++; if (state_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL key_sv_pulse: got %0b want 0", state_valid); end
    n_checks++; if (ostate[3] !== 64'h0123456789ABCDEF) begin n_fail++; $display("[TB] FAIL key_hold: got %h want 0123456789abcdef", ostate[3]); end
  endtask

  task automatic test_lsb();
    logic [4:0][63:0] s;
    rand_state(s);
    s[4] = '0;
    st = s; key = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_en = 1'b0; lsb_en = 1'b1; tag_en = 1'b0; valid = 1'b1;
    cycle();
    valid = 1'b0; lsb_en = 1'b0;
    n_checks++; if (ostate[4] !== 64'h1) begin n_fail++; $display("[TB] FAIL lsb_x4: got %h want 1", ostate[4]); end
    n_checks++; if (ostate[3:0] !== s[3:0]) begin n_fail++; $display("[TB] FAIL lsb_x0123: got %h want %h", ostate[3:0], s[3:0]); end
    cycle();
  endtask

  task automatic test_backpressure();
    logic [4:0][63:0] s;
    logic [63:0] x3, x4;
    rand_state(s);
    st = s; key = {$urandom(), $urandom(), $urandom(), $urandom()};
    x3 = s[3] ^ key[127:64];
    x4 = s[4] ^ key[63:0] ^ 64'h1;
    key_en = 1'b1; lsb_en = 1'b1; tag_en = 1'b1; valid = 1'b1; tag_ready = 1'b0;
    cycle();
    valid = 1'b0; key_en = 1'b0; lsb_en = 1'b0; tag_en = 1'b0;
    n_checks++; if (state_valid !== 1'b1 || tag_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL bp_latency: got sv=%0b tv=%0b want 1/1", state_valid, tag_valid); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (tag_valid !== 1'b1 || tag_data !== x3 || tag_last !== 1'b0 || ready !== 1'b0) begin
        n_fail++; $display("[TB] FAIL bp_hold_hi[%0d]: got v=%0b d=%h l=%0b r=%0b want 1/%h/0/0", i, tag_valid, tag_data, tag_last, ready, x3); end
      cycle();
    end
    tag_ready = 1'b1;
    cycle();
    n_checks++; if (tag_valid !== 1'b1 || tag_data !== x4 || tag_last !== 1'b1 || ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL bp_word_lo: got v=%0b d=%h l=%0b r=%0b want 1/%h/1/0", tag_valid, tag_data, tag_last, ready, x4); end
    cycle();
    tag_ready = 1'b0;
    n_checks++; if (ready !== 1'b1 || tag_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL bp_done: got r=%0b v=%0b want 1/0", ready, tag_valid); end
  endtask

  task automatic test_ignore_busy();
    logic [4:0][63:0] s, s2;
    rand_state(s);
    rand_state(s2);
    st = s; key_en = 1'b0; lsb_en = 1'b0; tag_en = 1'b1; valid = 1'b1; tag_ready = 1'b0;
    cycle();
    st = s2; key_en = 1'b1; lsb_en = 1'b1; valid = 1'b1;
    cycle();
    valid = 1'b0; tag_en = 1'b0; key_en = 1'b0; lsb_en = 1'b0;
    n_checks++; if (ostate !== s || state_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL busy_state: got %h sv=%0b want %h sv=0", ostate, state_valid, s); end
    n_checks++; if (tag_data !== s[3]) begin n_fail++; $display("[TB] FAIL busy_hi: got %h want %h", tag_data, s[3]); end
    tag_ready = 1'b1;
    cycle();
    n_checks++; if (tag_data !== s[4] || tag_last !== 1'b1) begin
      n_fail++; $display("[TB] FAIL busy_lo: got %h l=%0b want %h l=1", tag_data, tag_last, s[4]); end
    cycle();
    tag_ready = 1'b0;
    n_checks++; if (ostate !== s || ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL busy_after: got %h r=%0b want %h r=1", ostate, ready, s); end
  endtask

  task automatic test_reset_mid_tag();
    rand_state(st);
    tag_en = 1'b1; valid = 1'b1; tag_ready = 1'b0;
    cycle();
    valid = 1'b0; tag_en = 1'b0; tag_ready = 1'b1;
    cycle();
    tag_ready = 1'b0;
    n_checks++; if (tag_last !== 1'b1 || tag_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL rmid_in_lo: got v=%0b l=%0b want 1/1", tag_valid, tag_last); end
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    n_checks++; if (ostate !== '0 || state_valid !== 1'b0 || tag_valid !== 1'b0 || tag_last !== 1'b0 || tag_data !== 64'h0) begin
      n_fail++; $display("[TB] FAIL rmid_clear: got st=%h sv=%0b tv=%0b tl=%0b td=%h want all 0", ostate, state_valid, tag_valid, tag_last, tag_data); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_ready: got %0b want 1", ready); end
    tag_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (tag_valid !== 1'b0 || ostate !== '0) begin
        n_fail++; $display("[TB] FAIL rmid_no_word[%0d]: got tv=%0b st=%h want 0", i, tag_valid, ostate); end
    end
    tag_ready = 1'b0;
  endtask

  task automatic test_single_word();
    logic [4:0][63:0] s;
    rand_state(s);
    b_st = s; b_lsb_en = 1'b1; b_tag_ready = 1'b1; b_valid = 1'b1;
    cycle();
    b_valid = 1'b0; b_lsb_en = 1'b0;
    n_checks++; if (b_ostate[4] !== (s[4] ^ (64'd1 << 37)) || b_ostate[3:0] !== s[3:0]) begin
      n_fail++; $display("[TB] FAIL single_state: got %h want x4=%h", b_ostate, s[4] ^ (64'd1 << 37)); end
    n_checks++; if (b_tag_valid !== 1'b1 || b_tag_data !== s[3] || b_tag_last !== 1'b1 || b_ready !== 1'b0 || b_state_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL single_word: got v=%0b d=%h l=%0b r=%0b sv=%0b want 1/%h/1/0/1", b_tag_valid, b_tag_data, b_tag_last, b_ready, b_state_valid, s[3]); end
    cycle();
    n_checks++; if (b_ready !== 1'b1 || b_tag_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL single_ready: got r=%0b v=%0b want 1/0", b_ready, b_tag_valid); end
  endtask

  task automatic test_random();
    logic [63:0] exp_td;
    logic        exp_tl, exp_tv;
    for (int n = 0; n < 400; n++) begin
      rand_state(st);
      key       = {$urandom(), $urandom(), $urandom(), $urandom()};
      valid     = ($urandom_range(0, 1) == 1);
      key_en    = ($urandom_range(0, 1) == 1);
      lsb_en    = ($urandom_range(0, 1) == 1);
      tag_en    = ($urandom_range(0, 2) != 0);
      tag_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 63) == 0);
      cycle();
      exp_tv = (m_q.size() != 0);
      exp_td = exp_tv ? m_q[0][63:0] : 64'h0;
      exp_tl = exp_tv ? m_q[0][64] : 1'b0;
      n_checks++; if (ready !== !exp_tv || tag_valid !== exp_tv) begin
        n_fail++; $display("[TB] FAIL rnd_flow[%0d]: got r=%0b v=%0b want %0b/%0b", n, ready, tag_valid, !exp_tv, exp_tv); end
      n_checks++; if (tag_data !== exp_td || tag_last !== exp_tl) begin
        n_fail++; $display("[TB] FAIL rnd_tag[%0d]: got %h l=%0b want %h l=%0b", n, tag_data, tag_last, exp_td, exp_tl); end
      n_checks++; if (ostate !== m_state || state_valid !== m_sv) begin
        n_fail++; $display("[TB] FAIL rnd_state[%0d]: got %h sv=%0b want %h sv=%0b", n, ostate, state_valid, m_state, m_sv); end
    end
    reset = 1'b0; valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; st = '0; key = '0; valid = 1'b0;
    key_en = 1'b0; lsb_en = 1'b0; tag_en = 1'b0; tag_ready = 1'b0;
    b_st = '0; b_valid = 1'b0; b_lsb_en = 1'b0; b_tag_ready = 1'b0;
    m_state = '0; m_sv = 1'b0;
    test_reset();
    test_key_xor();
    test_lsb();
    test_backpressure();
    test_ignore_busy();
    test_reset_mid_tag();
    test_single_word();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
